// File: rtl/note_tone_gen.sv
// Buzzer tone stage: turns the sequencer's note/octave into a 50%-duty square wave.
// Optional articulation gap before each new note is built when NOTE_GAP_EN is defined.
module note_tone_gen #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int HP_W       = 20,
    parameter int GAP_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] note,
    input  logic [1:0] octave,
    output logic       buzzer,
    output logic       tone_active,
    output logic [3:0] cur_note,
    output logic [1:0] cur_octave
);

    function automatic int freq_hz(input int n);
        case (n)
            1:       freq_hz = 262;
            2:       freq_hz = 294;
            3:       freq_hz = 330;
            4:       freq_hz = 349;
            5:       freq_hz = 392;
            6:       freq_hz = 440;
            7:       freq_hz = 494;
            default: freq_hz = 1;
        endcase
    endfunction

`ifdef NOTE_GAP_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;
    localparam state_t ST_ENTRY = ST_GAP;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1
    } state_t;
    localparam state_t ST_ENTRY = ST_TONE;
`endif

    state_t          state_q, state_d;
    logic [HP_W-1:0] cnt_q, cnt_d;
    logic            buzzer_q, buzzer_d;
    logic [3:0]      cur_note_q, cur_note_d;
    logic [1:0]      cur_octave_q, cur_octave_d;

    // Mid-octave half periods; entry 0 is a harmless nonzero filler for non-pitched codes.
    logic [HP_W-1:0] hp_mid_tab [0:7];
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_hp
            if (gi == 0) begin : g_rest
                assign hp_mid_tab[gi] = HP_W'(2);
            end else begin : g_pitch
                localparam int HP_MID = CLK_HZ / (2 * freq_hz(gi));
                assign hp_mid_tab[gi] = HP_W'(HP_MID);
            end
        end
    endgenerate

    logic [HP_W-1:0] hp_base, hp, hp_last;
    logic            sounding, changed;

    always_comb begin
        hp_base = cur_note_q[3] ? hp_mid_tab[0] : hp_mid_tab[cur_note_q[2:0]];
        case (cur_octave_q)
            2'b00:   hp = hp_base << 1;
            2'b10:   hp = hp_base >> 1;
            default: hp = hp_base;
        endcase
        hp_last = hp - HP_W'(1);
    end

    assign sounding = enable && (note != 4'd0) && !note[3];
    assign changed  = ({note, octave} != {cur_note_q, cur_octave_q});

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        buzzer_d     = buzzer_q;
        // Latching on a change and always latching are the same thing.
        cur_note_d   = note;
        cur_octave_d = octave;
`ifdef NOTE_GAP_EN
        gap_cnt_d    = gap_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                buzzer_d = 1'b0;
                cnt_d    = '0;
                if (sounding) begin
                    state_d = ST_ENTRY;
`ifdef NOTE_GAP_EN
                    gap_cnt_d = '0;
`endif
                end
            end
            ST_TONE: begin
                if (!sounding) begin
                    state_d  = ST_IDLE;
                    buzzer_d = 1'b0;
                    cnt_d    = '0;
                end else if (changed) begin
                    state_d  = ST_ENTRY;
                    buzzer_d = 1'b0;
                    cnt_d    = '0;
`ifdef NOTE_GAP_EN
                    gap_cnt_d = '0;
`endif
                end else if (cnt_q >= hp_last) begin
                    buzzer_d = ~buzzer_q;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + HP_W'(1);
                end
            end
`ifdef NOTE_GAP_EN
            ST_GAP: begin
                buzzer_d = 1'b0;
                cnt_d    = '0;
                if (!sounding) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = '0;
                end else if (changed) begin
                    gap_cnt_d = '0;
                end else if (gap_cnt_q == GAP_LAST) begin
                    state_d   = ST_TONE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
`endif
            default: begin
                state_d  = ST_IDLE;
                buzzer_d = 1'b0;
                cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            buzzer_q     <= 1'b0;
            cur_note_q   <= 4'd0;
            cur_octave_q <= 2'd0;
`ifdef NOTE_GAP_EN
            gap_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            buzzer_q     <= buzzer_d;
            cur_note_q   <= cur_note_d;
            cur_octave_q <= cur_octave_d;
`ifdef NOTE_GAP_EN
            gap_cnt_q    <= gap_cnt_d;
`endif
        end
    end

    assign buzzer      = buzzer_q;
    assign tone_active = (state_q == ST_TONE);
    assign cur_note    = cur_note_q;
    assign cur_octave  = cur_octave_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen at CLK_HZ=8800 (mid note 6 -> half period 10 clocks).
// Builds with or without NOTE_GAP_EN; expected waveforms include the gap when it is enabled.
module tb_note_tone_gen;

    localparam int CLK_HZ     = 8800;
    localparam int HP_W       = 20;
    localparam int GAP_CYCLES = 4;
`ifdef NOTE_GAP_EN
    localparam int GAP = GAP_CYCLES;
`else
    localparam int GAP = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] note;
    logic [1:0] octave;
    logic       buzzer;
    logic       tone_active;
    logic [3:0] cur_note;
    logic [1:0] cur_octave;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    note_tone_gen #(
        .CLK_HZ    (CLK_HZ),
        .HP_W      (HP_W),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .note       (note),
        .octave     (octave),
        .buzzer     (buzzer),
        .tone_active(tone_active),
        .cur_note   (cur_note),
        .cur_octave (cur_octave)
    );

    task automatic test_reset;
        reset  = 1'b0;
        enable = 1'b1;
        note   = 4'd0;
        octave = 2'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({buzzer, tone_active, cur_note, cur_octave} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hold: buzzer=%b tone_active=%b cur_note=%0d cur_octave=%0d, expected all 0",
                     buzzer, tone_active, cur_note, cur_octave);
        end
        reset = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            n_checks++;
            if ({buzzer, tone_active, cur_note} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_idle clk %0d: buzzer=%b tone_active=%b cur_note=%0d, expected 0/0/0",
                         k, buzzer, tone_active, cur_note);
            end
        end
        $display("reset: 50 idle clocks checked");
    endtask

    // Note/octave vectors with hand-computed half periods (8800/(2f), truncated, then octave shift).
    task automatic test_tone_table;
        int t_note [7] = '{6, 6, 6, 6, 1, 7, 3};
        int t_oct  [7] = '{1, 0, 2, 3, 1, 2, 0};
        int t_hp   [7] = '{10, 20, 5, 10, 16, 4, 26};
        logic exp_b;
        logic exp_t;
        for (int i = 0; i < 7; i++) begin
            note   = 4'(t_note[i]);
            octave = 2'(t_oct[i]);
            for (int k = 1; k <= 3 * t_hp[i] + GAP + 1; k++) begin
                @(negedge clk);
                exp_t = (k > GAP);
                exp_b = (k <= GAP) ? 1'b0 : (((k - 1 - GAP) / t_hp[i]) % 2 != 0);
                n_checks++;
                if (buzzer !== exp_b || tone_active !== exp_t) begin
                    n_fail++;
                    $display("FAIL tone note%0d oct%0d clk %0d: buzzer=%b tone_active=%b, expected %b/%b",
                             t_note[i], t_oct[i], k, buzzer, tone_active, exp_b, exp_t);
                end
                if (k == 1) begin
                    n_checks++;
                    if (cur_note !== 4'(t_note[i]) || cur_octave !== 2'(t_oct[i])) begin
                        n_fail++;
                        $display("FAIL tone_latch: cur_note=%0d cur_octave=%0d, expected %0d/%0d",
                                 cur_note, cur_octave, t_note[i], t_oct[i]);
                    end
                end
            end
            $display("tone: note=%0d oct=%0d hp=%0d checked", t_note[i], t_oct[i], t_hp[i]);
        end
    endtask

    task automatic test_note_off;
        logic exp_b;
        int   codes [2] = '{0, 9};
        // Previous tone (note 3 low) ends with buzzer high.
        for (int c = 0; c < 2; c++) begin
            note = 4'(codes[c]);
            @(negedge clk);
            n_checks++;
            if (buzzer !== 1'b0 || tone_active !== 1'b0 || cur_note !== 4'(codes[c])) begin
                n_fail++;
                $display("FAIL note_off code %0d: buzzer=%b tone_active=%b cur_note=%0d, expected 0/0/%0d",
                         codes[c], buzzer, tone_active, cur_note, codes[c]);
            end
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                n_checks++;
                if (buzzer !== 1'b0 || tone_active !== 1'b0) begin
                    n_fail++;
                    $display("FAIL note_off_hold code %0d clk %0d: buzzer=%b tone_active=%b, expected 0/0",
                             codes[c], k, buzzer, tone_active);
                end
            end
            $display("note_off: code %0d silences next edge", codes[c]);
            if (c == 0) begin
                note   = 4'd6;
                octave = 2'd1;
                for (int k = 1; k <= 10 + GAP + 3; k++) begin
                    @(negedge clk);
                    exp_b = (k <= GAP) ? 1'b0 : (((k - 1 - GAP) / 10) % 2 != 0);
                    n_checks++;
                    if (buzzer !== exp_b) begin
                        n_fail++;
                        $display("FAIL note_off_restart clk %0d: buzzer=%b, expected %b", k, buzzer, exp_b);
                    end
                end
            end
        end
    endtask

    task automatic test_enable_drop;
        logic exp_b;
        note   = 4'd6;
        octave = 2'd1;
        for (int k = 1; k <= 10 + GAP + 3; k++) begin
            @(negedge clk);
            exp_b = (k <= GAP) ? 1'b0 : (((k - 1 - GAP) / 10) % 2 != 0);
            n_checks++;
            if (buzzer !== exp_b) begin
                n_fail++;
                $display("FAIL enable_pre clk %0d: buzzer=%b, expected %b", k, buzzer, exp_b);
            end
        end
        enable = 1'b0;
        @(negedge clk);
        n_checks++;
        if (buzzer !== 1'b0 || tone_active !== 1'b0 || cur_note !== 4'd6) begin
            n_fail++;
            $display("FAIL enable_drop: buzzer=%b tone_active=%b cur_note=%0d, expected 0/0/6",
                     buzzer, tone_active, cur_note);
        end
        note = 4'd2;
        @(negedge clk);
        n_checks++;
        if (cur_note !== 4'd2 || buzzer !== 1'b0 || tone_active !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_track: cur_note=%0d buzzer=%b tone_active=%b, expected 2/0/0",
                     cur_note, buzzer, tone_active);
        end
        note = 4'd6;
        @(negedge clk);
        enable = 1'b1;
        for (int k = 1; k <= 20 + GAP + 2; k++) begin
            @(negedge clk);
            exp_b = (k <= GAP) ? 1'b0 : (((k - 1 - GAP) / 10) % 2 != 0);
            n_checks++;
            if (buzzer !== exp_b || tone_active !== (k > GAP)) begin
                n_fail++;
                $display("FAIL enable_resume clk %0d: buzzer=%b tone_active=%b, expected %b/%b",
                         k, buzzer, tone_active, exp_b, (k > GAP));
            end
        end
        $display("enable: drop silences next edge, resume rises after 1+hp clocks");
    endtask

    task automatic test_back_to_back;
        logic exp_b;
        int   seq_note [2] = '{5, 6};
        int   seq_hp   [2] = '{11, 10};
        octave = 2'd1;
        for (int i = 0; i < 2; i++) begin
            note = 4'(seq_note[i]);
            for (int k = 1; k <= 2 * seq_hp[i] + GAP + 2; k++) begin
                @(negedge clk);
                exp_b = (k <= GAP) ? 1'b0 : (((k - 1 - GAP) / seq_hp[i]) % 2 != 0);
                n_checks++;
                if (buzzer !== exp_b || tone_active !== (k > GAP)) begin
                    n_fail++;
                    $display("FAIL back_to_back note%0d clk %0d: buzzer=%b tone_active=%b, expected %b/%b",
                             seq_note[i], k, buzzer, tone_active, exp_b, (k > GAP));
                end
            end
            $display("back_to_back: note %0d hp=%0d checked", seq_note[i], seq_hp[i]);
        end
    endtask

    task automatic test_change_during_gap;
        logic exp_b;
        note   = 4'd5;
        octave = 2'd1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (buzzer !== 1'b0 || tone_active !== (k > GAP)) begin
                n_fail++;
                $display("FAIL early_change clk %0d: buzzer=%b tone_active=%b, expected 0/%b",
                         k, buzzer, tone_active, (k > GAP));
            end
        end
        // Second change lands at clock 2 of the first note's gap: gap restarts in full.
        note = 4'd4;
        for (int k = 1; k <= 2 * 12 + GAP + 2; k++) begin
            @(negedge clk);
            exp_b = (k <= GAP) ? 1'b0 : (((k - 1 - GAP) / 12) % 2 != 0);
            n_checks++;
            if (buzzer !== exp_b || tone_active !== (k > GAP)) begin
                n_fail++;
                $display("FAIL gap_restart clk %0d: buzzer=%b tone_active=%b, expected %b/%b",
                         k, buzzer, tone_active, exp_b, (k > GAP));
            end
        end
        $display("change_during_gap: restart checked with note 4 hp=12");
    endtask

    task automatic test_reset_mid_tone;
        logic exp_b;
        note   = 4'd7;
        octave = 2'd1;
        for (int k = 1; k <= 8 + GAP + 2; k++) begin
            @(negedge clk);
            exp_b = (k <= GAP) ? 1'b0 : (((k - 1 - GAP) / 8) % 2 != 0);
            n_checks++;
            if (buzzer !== exp_b) begin
                n_fail++;
                $display("FAIL pre_reset clk %0d: buzzer=%b, expected %b", k, buzzer, exp_b);
            end
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({buzzer, tone_active, cur_note, cur_octave} !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: buzzer=%b tone_active=%b cur_note=%0d cur_octave=%0d, expected all 0",
                     buzzer, tone_active, cur_note, cur_octave);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 8 + GAP + 2; k++) begin
            @(negedge clk);
            exp_b = (k <= GAP) ? 1'b0 : (((k - 1 - GAP) / 8) % 2 != 0);
            n_checks++;
            if (buzzer !== exp_b || tone_active !== (k > GAP)) begin
                n_fail++;
                $display("FAIL post_reset clk %0d: buzzer=%b tone_active=%b, expected %b/%b",
                         k, buzzer, tone_active, exp_b, (k > GAP));
            end
        end
        $display("reset_mid_tone: async clear and restart checked");
    endtask

    initial begin
        test_reset();
        test_tone_table();
        test_note_off();
        test_enable_drop();
        test_back_to_back();
        test_change_during_gap();
        test_reset_mid_tone();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
